// File: rtl/rasterizer_pkg.sv
// Shared arbiter types and default Avalon widths.
// Imported by the SDRAM master arbiter and its tag FIFO users.
package rasterizer_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    localparam int AVM_ADDR_W = 26;
    localparam int AVM_DATA_W = 32;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order FIFO of channel tags for outstanding reads.
// Push is refused when full, pop when empty.
module arb_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = count == (AW+1)'(DEPTH);
    assign empty    = count == '0;
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Tag storage needs no reset: entries are only read behind count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/avalon_master_arbiter.sv
// N-channel Avalon-MM arbiter onto one SDRAM master port.
// Grants are locked until accepted; read responses routed by tag.
module avalon_master_arbiter
    import rasterizer_pkg::*;
#(
    parameter int        NUM_CH      = 3,
    parameter int        ADDR_W      = AVM_ADDR_W,
    parameter int        DATA_W      = AVM_DATA_W,
    parameter int        MAX_PENDING = 8,
    parameter arb_mode_e ARB_MODE    = ARB_RR
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_address,
    input  logic [NUM_CH-1:0]              ch_read,
    input  logic [NUM_CH-1:0]              ch_write,
    input  logic [NUM_CH-1:0][DATA_W/8-1:0] ch_byteenable,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_writedata,
    output logic [NUM_CH-1:0]              ch_waitrequest,
    output logic [DATA_W-1:0]              ch_readdata,
    output logic [NUM_CH-1:0]              ch_readdatavalid,
    output logic [ADDR_W-1:0]              mem_address,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [DATA_W/8-1:0]            mem_byteenable,
    output logic [DATA_W-1:0]              mem_writedata,
    input  logic [DATA_W-1:0]              mem_readdata,
    input  logic                           mem_readdatavalid,
    input  logic                           mem_waitrequest,
    output logic                           busy,
    output logic                           err_orphan
);

    localparam int TAG_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(MAX_PENDING) + 1;

    logic [TAG_W-1:0]  rr_ptr;
    logic [TAG_W-1:0]  lock_ch;
    logic              lock_q;
    logic [TAG_W-1:0]  grant;
    logic              grant_vld;
    logic [NUM_CH-1:0] eligible;
    logic              wr_sel;
    logic              rd_sel;
    logic              accept;
    logic              push;
    logic              pop;
    logic [TAG_W-1:0]  head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  pending;

    // A write is never held back by a full tag FIFO.
    assign eligible = ch_write | (ch_read & {NUM_CH{~fifo_full}});

    always_comb begin
        int idx;
        idx       = 0;
        grant     = lock_ch;
        grant_vld = 1'b0;
        if (lock_q && eligible[lock_ch]) begin
            grant_vld = 1'b1;
        end else if (ARB_MODE == ARB_FIXED) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    grant     = TAG_W'(i);
                    grant_vld = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx = (int'(rr_ptr) + k) % NUM_CH;
                if (!grant_vld && eligible[idx]) begin
                    grant     = TAG_W'(idx);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    assign wr_sel = grant_vld & ch_write[grant];
    assign rd_sel = grant_vld & ~ch_write[grant] & ch_read[grant];

    assign mem_write      = wr_sel & reset;
    assign mem_read       = rd_sel & reset;
    assign mem_address    = ch_address[grant];
    assign mem_byteenable = ch_byteenable[grant];
    assign mem_writedata  = ch_writedata[grant];

    assign accept = (mem_read | mem_write) & ~mem_waitrequest;
    assign push   = accept & mem_read;
    assign pop    = mem_readdatavalid & ~fifo_empty;

    always_comb begin
        ch_waitrequest   = '1;
        ch_readdatavalid = '0;
        if (accept) ch_waitrequest[grant] = 1'b0;
        if (pop)    ch_readdatavalid[head] = 1'b1;
    end

    assign ch_readdata = mem_readdata;
    assign busy        = pending != '0;

    arb_tag_fifo #(
        .DEPTH (MAX_PENDING),
        .WIDTH (TAG_W)
    ) u_tags (
        .clk       (clock),
        .rst_n     (reset),
        .push      (push),
        .push_data (grant),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (pending)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr     <= '0;
            lock_q     <= 1'b0;
            lock_ch    <= '0;
            err_orphan <= 1'b0;
        end else begin
            lock_q  <= (mem_read | mem_write) & mem_waitrequest;
            lock_ch <= grant;
            if (accept) rr_ptr <= TAG_W'((int'(grant) + 1) % NUM_CH);
            if (mem_readdatavalid && fifo_empty) err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_avalon_master_arbiter.sv
// Randomised and directed bench for avalon_master_arbiter.
// A queue-based transaction model predicts grants and routing.
module tb_avalon_master_arbiter;
    import rasterizer_pkg::*;

    logic              clock = 0;
    logic              reset = 0;
    logic [2:0][25:0]  ch_address;
    logic [2:0]        ch_read;
    logic [2:0]        ch_write;
    logic [2:0][3:0]   ch_byteenable;
    logic [2:0][31:0]  ch_writedata;
    logic [31:0]       mem_readdata;
    logic              mem_readdatavalid;
    logic              mem_waitrequest;

    logic [2:0]  ch_waitrequest, fx_ch_waitrequest;
    logic [31:0] ch_readdata, fx_ch_readdata;
    logic [2:0]  ch_readdatavalid, fx_ch_readdatavalid;
    logic [25:0] mem_address, fx_mem_address;
    logic        mem_read, fx_mem_read, mem_write, fx_mem_write;
    logic [3:0]  mem_byteenable, fx_mem_byteenable;
    logic [31:0] mem_writedata, fx_mem_writedata;
    logic        busy, fx_busy, err_orphan, fx_err_orphan;

    avalon_master_arbiter #(
        .NUM_CH(3), .ADDR_W(26), .DATA_W(32), .MAX_PENDING(8), .ARB_MODE(ARB_RR)
    ) dut (
        .clock(clock), .reset(reset),
        .ch_address(ch_address), .ch_read(ch_read), .ch_write(ch_write),
        .ch_byteenable(ch_byteenable), .ch_writedata(ch_writedata),
        .ch_waitrequest(ch_waitrequest), .ch_readdata(ch_readdata),
        .ch_readdatavalid(ch_readdatavalid),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
        .mem_waitrequest(mem_waitrequest), .busy(busy), .err_orphan(err_orphan)
    );

    avalon_master_arbiter #(
        .NUM_CH(3), .ADDR_W(26), .DATA_W(32), .MAX_PENDING(8), .ARB_MODE(ARB_FIXED)
    ) dut_fx (
        .clock(clock), .reset(reset),
        .ch_address(ch_address), .ch_read(ch_read), .ch_write(ch_write),
        .ch_byteenable(ch_byteenable), .ch_writedata(ch_writedata),
        .ch_waitrequest(fx_ch_waitrequest), .ch_readdata(fx_ch_readdata),
        .ch_readdatavalid(fx_ch_readdatavalid),
        .mem_address(fx_mem_address), .mem_read(fx_mem_read),
        .mem_write(fx_mem_write), .mem_byteenable(fx_mem_byteenable),
        .mem_writedata(fx_mem_writedata),
        .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
        .mem_waitrequest(mem_waitrequest), .busy(fx_busy),
        .err_orphan(fx_err_orphan)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state: outstanding read owners in issue order.
    int tagq[$];
    int rr_start = 0;
    int locked   = -1;
    bit orphan_m = 0;
    bit sel_fx   = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic bit elig(int c, logic [2:0] rd, logic [2:0] wr);
        return wr[c] || (rd[c] && tagq.size() < 8);
    endfunction

    task automatic cycle(input logic [2:0] rd, input logic [2:0] wr,
                         input logic wt, input logic rdv);
        int g;
        int c;
        bit acc;
        bit is_wr;
        logic [2:0] exp_wq;
        logic [2:0] exp_rdv;
        ch_read           = rd;
        ch_write          = wr;
        mem_waitrequest   = wt;
        mem_readdatavalid = rdv;
        mem_readdata      = $urandom;
        #2;
        g = -1;
        if (locked >= 0 && elig(locked, rd, wr)) g = locked;
        else
            for (int k = 0; k < 3; k++) begin
                c = sel_fx ? k : (rr_start + k) % 3;
                if (g < 0 && elig(c, rd, wr)) g = c;
            end
        is_wr  = g >= 0 && wr[g];
        acc    = g >= 0 && !wt;
        exp_wq = 3'b111;
        if (acc) exp_wq[g] = 1'b0;
        exp_rdv = 3'b000;
        if (rdv && tagq.size() > 0) exp_rdv[tagq[0]] = 1'b1;
        chk("mem_write", sel_fx ? fx_mem_write : mem_write, is_wr);
        chk("mem_read", sel_fx ? fx_mem_read : mem_read, g >= 0 && !is_wr);
        chk("waitrequest", sel_fx ? fx_ch_waitrequest : ch_waitrequest, exp_wq);
        chk("readdatavalid", sel_fx ? fx_ch_readdatavalid : ch_readdatavalid,
            exp_rdv);
        chk("busy", sel_fx ? fx_busy : busy, tagq.size() > 0);
        if (g >= 0)
            chk("address", sel_fx ? fx_mem_address : mem_address, ch_address[g]);
        if (is_wr) begin
            chk("writedata", sel_fx ? fx_mem_writedata : mem_writedata,
                ch_writedata[g]);
            chk("byteenable", sel_fx ? fx_mem_byteenable : mem_byteenable,
                ch_byteenable[g]);
        end
        if (exp_rdv != 0)
            chk("readdata", sel_fx ? fx_ch_readdata : ch_readdata, mem_readdata);
        @(posedge clock);
        if (rdv) begin
            if (tagq.size() > 0) void'(tagq.pop_front());
            else orphan_m = 1;
        end
        if (acc && !is_wr) tagq.push_back(g);
        locked = (g >= 0 && !acc) ? g : -1;
        if (acc) rr_start = (g + 1) % 3;
        #1;
        chk("err_orphan", sel_fx ? fx_err_orphan : err_orphan, orphan_m);
    endtask

    task automatic do_reset();
        reset = 0;
        #2;
        chk("rst_mem_read", sel_fx ? fx_mem_read : mem_read, 0);
        chk("rst_mem_write", sel_fx ? fx_mem_write : mem_write, 0);
        chk("rst_waitreq", sel_fx ? fx_ch_waitrequest : ch_waitrequest, 3'b111);
        chk("rst_rdv", sel_fx ? fx_ch_readdatavalid : ch_readdatavalid, 0);
        chk("rst_busy", sel_fx ? fx_busy : busy, 0);
        chk("rst_orphan", sel_fx ? fx_err_orphan : err_orphan, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1;
        tagq.delete();
        rr_start = 0;
        locked   = -1;
        orphan_m = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (tagq.size() > 0 && n < 64) begin
            cycle(3'b000, 3'b000, 0, 1);
            n++;
        end
        chk("drain_done", tagq.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            ch_address[i]    = 26'(32'h40 * (i + 1));
            ch_byteenable[i] = 4'hF;
            ch_writedata[i]  = 32'h1000 + i;
        end
        ch_read           = 3'b111;
        ch_write          = 3'b010;
        mem_readdata      = 0;
        mem_readdatavalid = 1;
        mem_waitrequest   = 0;
        #1;
        do_reset();

        // round-robin with every channel reading, then ordered responses
        for (int i = 0; i < 6; i++) cycle(3'b111, 3'b000, 0, 0);
        for (int i = 0; i < 6; i++) cycle(3'b000, 3'b000, 0, 1);

        // ch1 write stalled four cycles, ch0 arrives in cycle 2
        ch_address[1]   = 26'h100;
        ch_writedata[1] = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            cycle(i >= 1 ? 3'b001 : 3'b000, 3'b010, 1, 0);
            chk("lock_addr", mem_address, 26'h100);
        end
        cycle(3'b001, 3'b010, 0, 0);
        drain();

        // fill the tag FIFO from ch2; a write still gets through
        for (int i = 0; i < 8; i++) cycle(3'b100, 3'b000, 0, 0);
        cycle(3'b100, 3'b000, 0, 0);
        chk("full_no_read", mem_read, 0);
        chk("full_waitreq", ch_waitrequest, 3'b111);
        chk("full_busy", busy, 1);
        cycle(3'b100, 3'b001, 0, 0);
        cycle(3'b100, 3'b000, 0, 1);
        cycle(3'b100, 3'b000, 0, 0);
        drain();

        // orphan response is dropped and sticky
        cycle(3'b000, 3'b000, 0, 1);
        cycle(3'b000, 3'b000, 0, 0);
        cycle(3'b001, 3'b000, 0, 0);
        drain();
        ch_read = 3'b111;
        do_reset();

        // reset with three reads in flight
        for (int i = 0; i < 3; i++) cycle(3'b111, 3'b000, 0, 0);
        do_reset();
        cycle(3'b000, 3'b000, 0, 1);
        cycle(3'b000, 3'b000, 0, 1);
        do_reset();

        // random traffic
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 3; i++) begin
                ch_address[i]    = 26'($urandom);
                ch_writedata[i]  = $urandom;
                ch_byteenable[i] = 4'($urandom);
            end
            cycle(3'($urandom),
                  {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3) == 0},
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
        end
        drain();

        // fixed priority instance
        sel_fx = 1;
        ch_address[0] = 26'h0AA;
        ch_address[2] = 26'h2CC;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(3'b101, 3'b000, 0, i > 0);
            chk("fixed_ch0", fx_mem_address, 26'h0AA);
        end
        cycle(3'b100, 3'b000, 0, 1);
        cycle(3'b100, 3'b000, 0, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avalon_master_arbiter.md
AVALON_MASTER_ARBITER -- requirements
Module: avalon_master_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  NUM_CH  3  number of upstream pipeline masters (2..8)
  ADDR_W  26  Avalon word address width
  DATA_W  32  Avalon data width
  MAX_PENDING  8  outstanding-read capacity (power of 2, 2..32)
  ARB_MODE  ARB_RR  ARB_RR = round-robin, ARB_FIXED = channel 0 highest priority
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clock  in  1  single clock
  reset  in  1  asynchronous, active-low reset
  ch_address  in  NUM_CH x ADDR_W  per-channel address
  ch_read / ch_write  in  NUM_CH  per-channel requests
  ch_byteenable  in  NUM_CH x (DATA_W/8)  per-channel byte enables
  ch_writedata  in  NUM_CH x DATA_W  per-channel write data
  ch_waitrequest  out  NUM_CH  per-channel stall
  ch_readdata  out  DATA_W  broadcast read data
  ch_readdatavalid  out  NUM_CH  per-channel read strobe
  mem_address / mem_read / mem_write / mem_byteenable / mem_writedata  out  as above  shared SDRAM master
  mem_readdata  in  DATA_W;  mem_readdatavalid  in  1;  mem_waitrequest  in  1
  busy  out  1  outstanding reads > 0
  err_orphan  out  1  sticky: readdatavalid arrived with no outstanding read

Function
REQ-003 A channel SHALL be eligible when ch_read or ch_write is high; a read-only request SHALL be ineligible while pending == MAX_PENDING.
REQ-004 With no lock held, the grant SHALL go to the eligible channel chosen by ARB_MODE: ARB_RR searches from rr_ptr upward with wrap; ARB_FIXED picks the lowest index.
REQ-005 The granted channel's address/read/write/byteenable/writedata SHALL drive mem_* combinationally in the same cycle. With no grant, mem_read and mem_write SHALL be 0.
REQ-006 A transfer SHALL be accepted in a cycle where mem_read or mem_write is high and mem_waitrequest is 0. In that cycle ch_waitrequest[g] SHALL be 0; every other cycle, every channel's ch_waitrequest SHALL be 1.
REQ-007 If a granted request is not accepted, the arbiter SHALL register a lock on that channel. The grant SHALL stay locked until acceptance, regardless of higher-priority arrivals.
REQ-008 On acceptance, rr_ptr SHALL become (g+1) mod NUM_CH and the lock SHALL clear. A new grant MAY be issued in the following cycle, giving 1 transfer/cycle peak throughput.
REQ-009 Each accepted read SHALL push its channel index into an in-order tag FIFO and increment pending.
REQ-010 Each mem_readdatavalid SHALL pop the FIFO head h. In the same cycle, ch_readdatavalid[h] SHALL be 1 and ch_readdata SHALL equal mem_readdata; there are 0 cycles of added latency.
REQ-011 A push and a pop in the same cycle SHALL leave pending unchanged. A pop is permitted when pending == MAX_PENDING and the push is blocked.
REQ-012 mem_readdatavalid with pending == 0 SHALL be dropped: all ch_readdatavalid stay 0 and err_orphan is set until reset.
REQ-013 If ch_read and ch_write are both high on one channel, the write SHALL be served first. The read is then served as a separate subsequent transfer.
REQ-014 Writes SHALL NOT be blocked by a full tag FIFO.

Reset
REQ-015 While reset == 0, the following SHALL hold asynchronously: mem_read = mem_write = 0, ch_waitrequest = all 1, ch_readdatavalid = 0, busy = 0, err_orphan = 0, rr_ptr = 0, lock cleared, FIFO empty.
REQ-016 Reset mid-operation SHALL discard outstanding read tags. Responses arriving after reset deasserts SHALL be treated as orphans per REQ-012.

Structure
REQ-017 rasterizer_pkg SHALL hold the arb_mode_e typedef (ARB_RR, ARB_FIXED) and the default constants AVM_ADDR_W = 26 and AVM_DATA_W = 32.
REQ-018 The tag FIFO SHALL be a sub-module arb_tag_fifo, parametrised by depth and entry width $clog2(NUM_CH), with push/pop/full/empty/count ports.

Verification
REQ-019 NUM_CH=3, RR mode, all channels hold reads continuously, mem_waitrequest=0 -> grants follow 0,1,2,0,1,2, and responses are routed to the matching ch_readdatavalid bits in that order.
REQ-020 Ch1 writes 0xDEADBEEF to 0x100 while mem_waitrequest is held 1 for 4 cycles, and ch0 requests at cycle 2 -> mem_address stays 0x100 for all 5 cycles, and ch1 gets ch_waitrequest=0 only in cycle 5.
REQ-021 MAX_PENDING=8, 9 back-to-back reads from ch2 with no response -> the 9th read stalls and busy=1. A ch0 write issued meanwhile is accepted. One readdatavalid then unblocks the 9th read.
REQ-022 ARB_FIXED, ch0 and ch2 request continuously -> ch2 is never granted while ch0 requests, and is granted the cycle after ch0 drops.
REQ-023 mem_readdatavalid pulse with pending=0 -> no ch_readdatavalid is raised, err_orphan=1 and it stays set. Reset asserted -> err_orphan=0.
REQ-024 Reset pulsed with 3 reads outstanding -> busy=0 immediately. Post-reset responses are flagged as orphans and not delivered.
